kappa3_light_core: RTL and testbench

Multi-cycle RV32I-subset processor core with on-chip word memory and a debug port for loading and inspecting state. Each instruction runs in four phases (IF, DE, EX, WB), one phase per enabled clock. The core sits under a board-level controller that drives run/step controls and debug strobes. It is also the unit exercised by the simulation bench.

---
 rtl/kappa3_light_core.sv | 245 ++++++++++++++++++++++++
 tb/tb_kappa3_light_core.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/kappa3_light_core.sv
// kappa3_light_core: multi-cycle RV32I-subset core (IF/DE/EX/WB) with word memory and debug port.
// Optional build macro: KAPPA3_LIGHT_STEP_PHASE_EN enables single-phase stepping via step_phase.
module kappa3_light_core #(
    parameter int MEM_WORDS = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        clock2,
    input  logic        run,
    input  logic        step_phase,
    input  logic        step_inst,
    output logic [3:0]  cstate,
    output logic        running,
    input  logic [31:0] dbg_in,
    input  logic        dbg_pc_ld,
    input  logic        dbg_ir_ld,
    input  logic        dbg_a_ld,
    input  logic        dbg_b_ld,
    input  logic        dbg_c_ld,
    input  logic        dbg_reg_ld,
    input  logic [4:0]  dbg_reg_addr,
    input  logic [31:0] dbg_mem_addr,
    input  logic        dbg_mem_read,
    input  logic        dbg_mem_write,
    output logic [31:0] dbg_pc_out,
    output logic [31:0] dbg_ir_out,
    output logic [31:0] dbg_a_out,
    output logic [31:0] dbg_b_out,
    output logic [31:0] dbg_c_out,
    output logic [31:0] dbg_reg_out,
    output logic [31:0] dbg_mem_out
);

    localparam int AW = $clog2(MEM_WORDS);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [3:0] {
        PH_IF = 4'b0001,
        PH_DE = 4'b0010,
        PH_EX = 4'b0100,
        PH_WB = 4'b1000
    } phase_t;

    phase_t      phase;
    logic [31:0] pc, ir, a, b, c;
    logic        taken;
    logic [31:0] rf  [32];
    logic [31:0] mem [MEM_WORDS];

    logic si_q, sp_q, inst_pend, ph_pend, ph_req;
    logic si_rise, sp_rise, advance;

`ifdef KAPPA3_LIGHT_STEP_PHASE_EN
    assign ph_req = step_phase;
`else
    logic unused_step_phase;
    assign ph_req            = 1'b0;
    assign unused_step_phase = step_phase;
`endif

    logic unused_addr_bits;
    assign unused_addr_bits = ^{dbg_mem_addr[31:AW+2], dbg_mem_addr[1:0]};

    assign si_rise = step_inst & ~si_q;
    assign sp_rise = ph_req & ~sp_q;
    assign running = run | inst_pend | ph_pend;
    assign advance = clock2 & running;

    assign cstate      = phase;
    assign dbg_pc_out  = pc;
    assign dbg_ir_out  = ir;
    assign dbg_a_out   = a;
    assign dbg_b_out   = b;
    assign dbg_c_out   = c;

    // Instruction fields and immediates
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic        f7b5, alt, is_lw, is_sw, writes_rd;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode = ir[6:0];
    assign rd     = ir[11:7];
    assign f3     = ir[14:12];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];
    assign f7b5   = ir[30];
    assign imm_i  = {{20{ir[31]}}, ir[31:20]};
    assign imm_s  = {{20{ir[31]}}, ir[31:25], ir[11:7]};
    assign imm_b  = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    assign imm_u  = {ir[31:12], 12'b0};
    assign imm_j  = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

    // bit 30 selects SUB only for register ops; SRA/SRAI for both
    assign alt       = f7b5 & ((opcode == OPC_OP) | (f3 == 3'b101));
    assign is_lw     = (opcode == OPC_LOAD)  && (f3 == 3'b010);
    assign is_sw     = (opcode == OPC_STORE) && (f3 == 3'b010);
    assign writes_rd = is_lw || (opcode == OPC_LUI) || (opcode == OPC_AUIPC) ||
                       (opcode == OPC_OP) || (opcode == OPC_OPIMM) ||
                       (opcode == OPC_JAL) || (opcode == OPC_JALR);

    function automatic logic [31:0] alu(input logic [2:0] fn, input logic alt_op,
                                        input logic [31:0] x, input logic [31:0] y);
        logic signed [31:0] xs, ys;
        xs = x;
        ys = y;
        case (fn)
            3'b000:  alu = alt_op ? x - y : x + y;
            3'b001:  alu = x << y[4:0];
            3'b010:  alu = {31'b0, xs < ys};
            3'b011:  alu = {31'b0, x < y};
            3'b100:  alu = x ^ y;
            3'b101:  alu = alt_op ? $unsigned(xs >>> y[4:0]) : x >> y[4:0];
            3'b110:  alu = x | y;
            default: alu = x & y;
        endcase
    endfunction

    function automatic logic branch_taken(input logic [2:0] fn,
                                          input logic [31:0] x, input logic [31:0] y);
        logic signed [31:0] xs, ys;
        xs = x;
        ys = y;
        case (fn)
            3'b000:  branch_taken = (x == y);
            3'b001:  branch_taken = (x != y);
            3'b100:  branch_taken = (xs < ys);
            3'b101:  branch_taken = (xs >= ys);
            3'b110:  branch_taken = (x < y);
            3'b111:  branch_taken = (x >= y);
            default: branch_taken = 1'b0;
        endcase
    endfunction

    logic [31:0] ex_result, next_pc;

    always_comb begin
        ex_result = '0;
        case (opcode)
            OPC_LUI:           ex_result = imm_u;
            OPC_AUIPC:         ex_result = pc + imm_u;
            OPC_OP:            ex_result = alu(f3, alt, a, b);
            OPC_OPIMM:         ex_result = alu(f3, alt, a, imm_i);
            OPC_LOAD:          ex_result = a + imm_i;
            OPC_STORE:         ex_result = a + imm_s;
            OPC_JAL, OPC_JALR: ex_result = pc + 32'd4;
            default:           ex_result = '0;
        endcase
    end

    always_comb begin
        next_pc = pc + 32'd4;
        case (opcode)
            OPC_JAL:    next_pc = pc + imm_j;
            OPC_JALR:   next_pc = (a + imm_i) & ~32'd1;
            OPC_BRANCH: if (taken) next_pc = pc + imm_b;
            default:    next_pc = pc + 32'd4;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            phase       <= PH_IF;
            pc          <= '0;
            ir          <= '0;
            a           <= '0;
            b           <= '0;
            c           <= '0;
            taken       <= 1'b0;
            si_q        <= 1'b0;
            sp_q        <= 1'b0;
            inst_pend   <= 1'b0;
            ph_pend     <= 1'b0;
            dbg_reg_out <= '0;
            dbg_mem_out <= '0;
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else begin
            si_q <= step_inst;
            sp_q <= ph_req;
            // A new request wins over the completion that clears the old one
            if (si_rise)
                inst_pend <= 1'b1;
            else if (advance && phase == PH_WB)
                inst_pend <= 1'b0;
            if (sp_rise)
                ph_pend <= 1'b1;
            else if (advance)
                ph_pend <= 1'b0;

            if (advance) begin
                case (phase)
                    PH_IF: begin
                        ir    <= mem[pc[AW+1:2]];
                        phase <= PH_DE;
                    end
                    PH_DE: begin
                        a     <= rf[rs1];
                        b     <= rf[rs2];
                        phase <= PH_EX;
                    end
                    PH_EX: begin
                        c     <= ex_result;
                        taken <= branch_taken(f3, a, b);
                        phase <= PH_WB;
                    end
                    default: begin
                        if (writes_rd && rd != 5'd0)
                            rf[rd] <= is_lw ? mem[c[AW+1:2]] : c;
                        pc    <= next_pc;
                        phase <= PH_IF;
                    end
                endcase
            end

            if (!running) begin
                if (dbg_pc_ld)    pc          <= dbg_in;
                if (dbg_ir_ld)    ir          <= dbg_in;
                if (dbg_a_ld)     a           <= dbg_in;
                if (dbg_b_ld)     b           <= dbg_in;
                if (dbg_c_ld)     c           <= dbg_in;
                if (dbg_reg_ld)   dbg_reg_out <= rf[dbg_reg_addr];
                if (dbg_mem_read) dbg_mem_out <= mem[dbg_mem_addr[AW+1:2]];
            end
        end
    end

    // Memory is not reset; stores and debug writes never coincide since one needs running
    always_ff @(posedge clock) begin
        if (reset && advance && phase == PH_WB && is_sw)
            mem[c[AW+1:2]] <= b;
        if (reset && !running && dbg_mem_write)
            mem[dbg_mem_addr[AW+1:2]] <= dbg_in;
    end

endmodule

// File: tb/tb_kappa3_light_core.sv
// Scoreboard bench for kappa3_light_core: expected results queued at stimulus time, popped on readback.
module tb_kappa3_light_core;

    logic        clock = 1'b0, reset = 1'b0, clock2 = 1'b0;
    logic        run = 1'b0, step_phase = 1'b0, step_inst = 1'b0;
    logic [3:0]  cstate;
    logic        running;
    logic [31:0] dbg_in = '0;
    logic        dbg_pc_ld = 0, dbg_ir_ld = 0, dbg_a_ld = 0, dbg_b_ld = 0, dbg_c_ld = 0;
    logic        dbg_reg_ld = 0, dbg_mem_read = 0, dbg_mem_write = 0;
    logic [4:0]  dbg_reg_addr = '0;
    logic [31:0] dbg_mem_addr = '0;
    logic [31:0] dbg_pc_out, dbg_ir_out, dbg_a_out, dbg_b_out, dbg_c_out;
    logic [31:0] dbg_reg_out, dbg_mem_out;

    kappa3_light_core #(.MEM_WORDS(1024)) dut (
        .clock(clock), .reset(reset), .clock2(clock2), .run(run),
        .step_phase(step_phase), .step_inst(step_inst),
        .cstate(cstate), .running(running), .dbg_in(dbg_in),
        .dbg_pc_ld(dbg_pc_ld), .dbg_ir_ld(dbg_ir_ld), .dbg_a_ld(dbg_a_ld),
        .dbg_b_ld(dbg_b_ld), .dbg_c_ld(dbg_c_ld), .dbg_reg_ld(dbg_reg_ld),
        .dbg_reg_addr(dbg_reg_addr), .dbg_mem_addr(dbg_mem_addr),
        .dbg_mem_read(dbg_mem_read), .dbg_mem_write(dbg_mem_write),
        .dbg_pc_out(dbg_pc_out), .dbg_ir_out(dbg_ir_out), .dbg_a_out(dbg_a_out),
        .dbg_b_out(dbg_b_out), .dbg_c_out(dbg_c_out),
        .dbg_reg_out(dbg_reg_out), .dbg_mem_out(dbg_mem_out)
    );

    always #5 clock = ~clock;
    always @(posedge clock) clock2 <= ~clock2;

    int          n_checks = 0;
    int          n_errors = 0;
    string       tag_q[$];
    logic [31:0] val_q[$];
    logic [31:0] v;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic expect_val(input string tag, input logic [31:0] val);
        tag_q.push_back(tag);
        val_q.push_back(val);
    endtask

    task automatic check_next(input logic [31:0] act);
        if (tag_q.size() == 0)
            check("sb_underflow", 32'(tag_q.size()), 32'd1);
        else
            check(tag_q.pop_front(), act, val_q.pop_front());
    endtask

    task automatic set_pc(input logic [31:0] val);
        @(negedge clock);
        dbg_in = val; dbg_pc_ld = 1'b1;
        @(negedge clock);
        dbg_pc_ld = 1'b0;
    endtask

    task automatic mem_wr(input logic [31:0] addr, input logic [31:0] val);
        @(negedge clock);
        dbg_in = val; dbg_mem_addr = addr; dbg_mem_write = 1'b1;
        @(negedge clock);
        dbg_mem_write = 1'b0;
    endtask

    task automatic read_reg(input logic [4:0] idx, output logic [31:0] val);
        @(negedge clock);
        dbg_reg_addr = idx; dbg_reg_ld = 1'b1;
        @(negedge clock);
        dbg_reg_ld = 1'b0;
        val = dbg_reg_out;
    endtask

    task automatic read_mem(input logic [31:0] addr, output logic [31:0] val);
        @(negedge clock);
        dbg_mem_addr = addr; dbg_mem_read = 1'b1;
        @(negedge clock);
        dbg_mem_read = 1'b0;
        val = dbg_mem_out;
    endtask

    task automatic wait_idle();
        int k = 0;
        @(negedge clock);
        while (running && k < 60) begin
            @(negedge clock);
            k++;
        end
        check("idle_timeout", 32'(running), 32'd0);
    endtask

    task automatic do_step_inst();
        @(negedge clock);
        step_inst = 1'b1;
        @(negedge clock);
        step_inst = 1'b0;
        wait_idle();
    endtask

    task automatic do_step_phase();
        @(negedge clock);
        step_phase = 1'b1;
        @(negedge clock);
        step_phase = 1'b0;
    endtask

    task automatic exec_at(input logic [31:0] addr, input logic [31:0] instr);
        set_pc(addr);
        mem_wr(addr, instr);
        do_step_inst();
    endtask

    initial begin
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("rst_cstate",  32'(cstate),  32'h1);
        check("rst_running", 32'(running), 32'h0);
        check("rst_pc",      dbg_pc_out,  32'h0);
        check("rst_ir",      dbg_ir_out,  32'h0);
        check("rst_a",       dbg_a_out,   32'h0);
        check("rst_b",       dbg_b_out,   32'h0);
        check("rst_c",       dbg_c_out,   32'h0);
        check("rst_regout",  dbg_reg_out, 32'h0);
        check("rst_memout",  dbg_mem_out, 32'h0);

        // LUI x1,0x12345 at an aliased address
        expect_val("lui_x1", 32'h12345000);
        expect_val("lui_pc", 32'h10000004);
        exec_at(32'h10000000, 32'h123450B7);
        read_reg(5'd1, v); check_next(v);
        check_next(dbg_pc_out);
        check("lui_cstate",  32'(cstate),  32'h1);
        check("lui_running", 32'(running), 32'h0);
        for (int r = 2; r < 32; r++) begin
            read_reg(5'(r), v);
            check($sformatf("x%0d_zero", r), v, 32'h0);
        end

        // Arithmetic: ADDI, ADD, SRAI
        expect_val("addi_x2", 32'hFFFFFFFB);
        mem_wr(32'h10000004, 32'hFFB00113);
        do_step_inst();
        read_reg(5'd2, v); check_next(v);
        expect_val("add_x3", 32'hFFFFFFF6);
        mem_wr(32'h10000008, 32'h002101B3);
        do_step_inst();
        read_reg(5'd3, v); check_next(v);
        expect_val("srai_x6", 32'hFFFFFFFD);
        expect_val("srai_pc", 32'h10000010);
        mem_wr(32'h1000000C, 32'h40115313);
        do_step_inst();
        read_reg(5'd6, v); check_next(v);
        check_next(dbg_pc_out);

        // SW x2,8(x0) then LW x4,8(x0)
        expect_val("sw_mem8", 32'hFFFFFFFB);
        expect_val("lw_x4",   32'hFFFFFFFB);
        exec_at(32'h10000010, 32'h00202423);
        exec_at(32'h10000014, 32'h00802203);
        read_mem(32'h8, v);  check_next(v);
        read_reg(5'd4, v);   check_next(v);

        // Branches and JAL
        expect_val("beq_pc", 32'h20);
        exec_at(32'h10, 32'h00000863);
        check_next(dbg_pc_out);
        expect_val("bne_pc", 32'h14);
        exec_at(32'h10, 32'h00001863);
        check_next(dbg_pc_out);
        expect_val("jal_pc", 32'h48);
        expect_val("jal_x5", 32'h44);
        exec_at(32'h40, 32'h008002EF);
        check_next(dbg_pc_out);
        read_reg(5'd5, v); check_next(v);

        // Phase stepping
        set_pc(32'h80);
        mem_wr(32'h80, 32'h00000013);
`ifdef KAPPA3_LIGHT_STEP_PHASE_EN
        expect_val("phase1", 32'h2);
        expect_val("phase2", 32'h4);
        expect_val("phase3", 32'h8);
        expect_val("phase4", 32'h1);
        for (int i = 0; i < 4; i++) begin
            do_step_phase();
            wait_idle();
            check_next(32'(cstate));
        end
        expect_val("phase_pc", 32'h84);
        check_next(dbg_pc_out);
`else
        expect_val("phase_ign_cstate", 32'h1);
        expect_val("phase_ign_pc",     32'h80);
        do_step_phase();
        repeat (10) @(negedge clock);
        check_next(32'(cstate));
        check_next(dbg_pc_out);
        check("phase_ign_running", 32'(running), 32'h0);
`endif

        // Run a 3-instruction program, then reset mid-EX
        mem_wr(32'h100, 32'h00100393);
        mem_wr(32'h104, 32'h00200413);
        mem_wr(32'h108, 32'h00300493);
        set_pc(32'h100);
        @(negedge clock);
        run = 1'b1;
        begin
            int k = 0;
            while (cstate != 4'b0010 && k < 20) begin
                @(negedge clock);
                k++;
            end
        end
        check("wait_de", 32'(cstate), 32'h2);
        expect_val("run_dbg_ignored", 32'h100);
        set_pc(32'hDEAD0000);
        check_next(dbg_pc_out);
        begin
            int k = 0;
            while (!(dbg_pc_out == 32'h108 && cstate == 4'b0100) && k < 80) begin
                @(negedge clock);
                k++;
            end
        end
        check("wait_ex3", 32'(cstate), 32'h4);
        reset = 1'b0;
        run   = 1'b0;
        @(negedge clock);
        check("mid_rst_cstate",  32'(cstate),  32'h1);
        check("mid_rst_running", 32'(running), 32'h0);
        check("mid_rst_pc",      dbg_pc_out,  32'h0);
        check("mid_rst_ir",      dbg_ir_out,  32'h0);
        check("mid_rst_a",       dbg_a_out,   32'h0);
        check("mid_rst_c",       dbg_c_out,   32'h0);
        @(negedge clock);
        reset = 1'b1;
        expect_val("mid_rst_x7", 32'h0);
        expect_val("mid_rst_x8", 32'h0);
        read_reg(5'd7, v); check_next(v);
        read_reg(5'd8, v); check_next(v);
        check("post_rst_running", 32'(running), 32'h0);
        check("post_rst_cstate",  32'(cstate),  32'h1);

        check("sb_drain", 32'(tag_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
